// File: rtl/degamma_1_8.sv
// degamma_1_8 -- inverse gamma-1.8 stage: 12-bit encoded component -> 8-bit linear.
// Eight pipelined binary-search ranks over a 255-entry threshold table; rank i
// resolves output bit (7-i). Valid/ready flow control uses a single global advance.
// Optional feature macro: DEGAMMA_BYPASS_EN (adds I_bypass; a bypassed word
// leaves as x[11:4] with the same latency and handshake).
module degamma_1_8 #(
    parameter int USER_W = 3
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic [11:0]       I_data,
    input  logic [USER_W-1:0] I_user,
    input  logic              I_valid,
    output logic              O_ready,
    output logic [7:0]        O_data,
    output logic [USER_W-1:0] O_user,
    output logic              O_valid,
`ifdef DEGAMMA_BYPASS_EN
    input  logic              I_bypass,
`endif
    input  logic              I_ready
);

    typedef logic [255:0][11:0] rom_t;

    // Unsigned power on a wide integer; used only while building the table.
    function automatic logic [159:0] pow_u(input logic [159:0] b, input int n);
        logic [159:0] acc;
        acc = 160'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * b;
        end
        return acc;
    endfunction

    // T[k] is the smallest x with 255*(x/4095)^1.8 >= k-0.5. Raising both sides
    // to the 5th power gives the exact integer test
    //   x^9 * 510^5 >= (2k-1)^5 * 4095^9
    // so the table is exact (no floating point), and T[k] = ceil(4095*((k-0.5)/255)^(1/1.8)).
    function automatic rom_t build_rom();
        rom_t         rom;
        logic [159:0] scale_x;
        logic [159:0] scale_k;
        logic [159:0] rhs;
        int           lo;
        int           hi;
        int           mid;
        rom     = '0;
        scale_x = pow_u(160'd510, 5);
        scale_k = pow_u(160'd4095, 9);
        for (int k = 1; k < 256; k++) begin
            rhs = pow_u(160'(2 * k - 1), 5) * scale_k;
            lo  = 0;
            hi  = 4095;
            while (lo < hi) begin
                mid = (lo + hi) / 2;
                if (pow_u(160'(mid), 9) * scale_x >= rhs) begin
                    hi = mid;
                end else begin
                    lo = mid + 1;
                end
            end
            rom[k] = 12'(lo);
        end
        return rom;
    endfunction

    localparam rom_t T_ROM = build_rom();

    // One search step: try setting bit s of the partial result.
    function automatic logic [7:0] search_step(input logic [11:0] x,
                                               input logic [7:0]  res,
                                               input int          s);
        logic [7:0] cand;
        cand = res | (8'd1 << s);
        if (x >= T_ROM[cand]) begin
            return cand;
        end else begin
            return res;
        end
    endfunction

    logic [11:0]       x_q    [8];
    logic [11:0]       x_d    [8];
    logic [7:0]        res_q  [8];
    logic [7:0]        res_d  [8];
    logic [USER_W-1:0] user_q [8];
    logic [USER_W-1:0] user_d [8];
    logic [7:0]        vld_q;
    logic [7:0]        vld_d;
`ifdef DEGAMMA_BYPASS_EN
    logic [6:0]        byp_q;
    logic [6:0]        byp_d;
`endif
    logic              en_s;

    // Global advance: the pipe moves whenever the output slot is empty or being taken.
    assign en_s    = ~vld_q[7] | I_ready;
    assign O_ready = en_s;
    assign O_data  = res_q[7];
    assign O_user  = user_q[7];
    assign O_valid = vld_q[7];

    // Next-state of every rank: rank 0 from the input port, rank i from rank i-1.
    always_comb begin
        x_d[0]    = I_data;
        res_d[0]  = search_step(I_data, 8'd0, 7);
        user_d[0] = I_user;
        for (int i = 1; i < 7; i++) begin
            x_d[i]    = x_q[i-1];
            res_d[i]  = search_step(x_q[i-1], res_q[i-1], 7 - i);
            user_d[i] = user_q[i-1];
        end
        x_d[7]    = x_q[6];
        user_d[7] = user_q[6];
`ifdef DEGAMMA_BYPASS_EN
        byp_d     = {byp_q[5:0], I_bypass};
        res_d[7]  = byp_q[6] ? x_q[6][11:4] : search_step(x_q[6], res_q[6], 0);
`else
        res_d[7]  = search_step(x_q[6], res_q[6], 0);
`endif
        vld_d     = {vld_q[6:0], I_valid};
    end

    // Pipeline ranks: clear on reset, shift together on advance, otherwise hold.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int i = 0; i < 8; i++) begin
                x_q[i]    <= 12'd0;
                res_q[i]  <= 8'd0;
                user_q[i] <= {USER_W{1'b0}};
            end
            vld_q <= 8'd0;
`ifdef DEGAMMA_BYPASS_EN
            byp_q <= 7'd0;
`endif
        end else if (en_s) begin
            for (int i = 0; i < 8; i++) begin
                x_q[i]    <= x_d[i];
                res_q[i]  <= res_d[i];
                user_q[i] <= user_d[i];
            end
            vld_q <= vld_d;
`ifdef DEGAMMA_BYPASS_EN
            byp_q <= byp_d;
`endif
        end
    end

endmodule

// File: tb/tb_degamma_1_8.sv
// tb_degamma_1_8 -- directed bench for degamma_1_8 with a small scoreboard.
// Inputs change #1 after the rising edge; outputs are observed on the falling edge.
module tb_degamma_1_8;

    localparam int USER_W = 3;

    logic              I_clk = 1'b0;
    logic              I_rst;
    logic [11:0]       I_data;
    logic [USER_W-1:0] I_user;
    logic              I_valid;
    logic              O_ready;
    logic [7:0]        O_data;
    logic [USER_W-1:0] O_user;
    logic              O_valid;
    logic              I_ready;
`ifdef DEGAMMA_BYPASS_EN
    logic              tb_byp = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int out_cnt  = 0;
    bit lat_en   = 1'b0;

    logic [7:0]        exp_d_q [$];
    logic [USER_W-1:0] exp_u_q [$];
    int                exp_a_q [$];

    degamma_1_8 #(.USER_W(USER_W)) dut (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_data  (I_data),
        .I_user  (I_user),
        .I_valid (I_valid),
        .O_ready (O_ready),
        .O_data  (O_data),
        .O_user  (O_user),
        .O_valid (O_valid),
`ifdef DEGAMMA_BYPASS_EN
        .I_bypass(tb_byp),
`endif
        .I_ready (I_ready)
    );

    always #5 I_clk = ~I_clk;

    always @(posedge I_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference transfer function in floating point.
    function automatic logic [7:0] ref_fn(input int x);
        real v;
        v = 255.0 * ((real'(x) / 4095.0) ** 1.8);
        v = $floor(v + 0.5);
        if (v > 255.0) v = 255.0;
        if (v < 0.0) v = 0.0;
        return 8'(int'(v));
    endfunction

    // Threshold T[k] straight from its closed form.
    function automatic int t_of(input int k);
        return int'($ceil(4095.0 * (((real'(k) - 0.5) / 255.0) ** (1.0 / 1.8))));
    endfunction

    // Output scoreboard: every transfer must match the oldest expected word.
    always @(negedge I_clk) begin : mon
        logic [7:0]        d;
        logic [USER_W-1:0] u;
        int                a;
        if (!I_rst && O_valid && I_ready) begin
            out_cnt++;
            check_eq("output_has_expected_word", exp_d_q.size() > 0, 1);
            if (exp_d_q.size() > 0) begin
                d = exp_d_q.pop_front();
                u = exp_u_q.pop_front();
                a = exp_a_q.pop_front();
                check_eq("o_data", O_data, d);
                check_eq("o_user", O_user, u);
                if (a >= 0) check_eq("latency", cyc - a + 1, 8);
            end
        end
    end

    task automatic send(input logic [11:0] x, input logic [USER_W-1:0] u, input logic [7:0] e);
        bit acc;
        acc     = 1'b0;
        I_data  = x;
        I_user  = u;
        I_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge I_clk);
            if (O_ready) begin
                acc = 1'b1;
                exp_d_q.push_back(e);
                exp_u_q.push_back(u);
                exp_a_q.push_back(lat_en ? cyc + 1 : -1);
            end
            @(posedge I_clk);
            #1;
        end
        I_valid = 1'b0;
        check_eq("send_accepted", acc, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge I_clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_d_q.size() > 0; t++) idle(1);
        check_eq("drain_empty", exp_d_q.size(), 0);
    endtask

    initial begin
        I_rst   = 1'b1;
        I_data  = 12'd0;
        I_user  = 3'd0;
        I_valid = 1'b0;
        I_ready = 1'b0;
        idle(3);
        check_eq("rst_o_valid", O_valid, 0);
        check_eq("rst_o_data", O_data, 0);
        check_eq("rst_o_user", O_user, 0);
        I_rst = 1'b0;
        idle(1);
        check_eq("o_ready_after_rst", O_ready, 1);
        I_ready = 1'b1;

        // Back-to-back stream with hand-computed results and latency 8.
        lat_en = 1'b1;
        send(12'd0,    3'd1, 8'd0);
        send(12'd1024, 3'd2, 8'd21);
        send(12'd2048, 3'd3, 8'd73);
        send(12'd4095, 3'd4, 8'd255);
        lat_en = 1'b0;
        drain();

        // Threshold edges for every k.
        for (int k = 1; k < 256; k++) begin
            send(12'(t_of(k) - 1), 3'(k), 8'(k - 1));
            send(12'(t_of(k)),     3'(k), 8'(k));
        end
        drain();

        // Exhaustive sweep against the floating-point model.
        for (int x = 0; x < 4096; x++) send(12'(x), 3'(x), ref_fn(x));
        drain();

        // Backpressure: 5-cycle stall while the source keeps offering words.
        fork
            begin
                for (int i = 0; i < 16; i++) send(12'(i * 256 + 7), 3'(i), ref_fn(i * 256 + 7));
            end
            begin
                idle(12);
                I_ready = 1'b0;
                repeat (5) begin
                    @(negedge I_clk);
                    check_eq("stall_o_ready", O_ready, 0);
                    check_eq("stall_o_valid", O_valid, 1);
                    check_eq("stall_o_data", O_data, exp_d_q[0]);
                    check_eq("stall_o_user", O_user, exp_u_q[0]);
                    @(posedge I_clk);
                    #1;
                end
                I_ready = 1'b1;
            end
        join
        drain();

        // Sideband with bubbles; fixed latency shows the gaps are kept.
        lat_en = 1'b1;
        send(12'd100,  3'b101, ref_fn(100));
        idle(2);
        send(12'd2000, 3'b010, ref_fn(2000));
        idle(1);
        send(12'd3500, 3'b111, ref_fn(3500));
        lat_en = 1'b0;
        drain();

        // Reset with 5 words in flight: none may emerge afterwards.
        for (int i = 0; i < 5; i++) send(12'(3000 + i * 200), 3'b111, ref_fn(3000 + i * 200));
        I_rst = 1'b1;
        exp_d_q.delete();
        exp_u_q.delete();
        exp_a_q.delete();
        out_cnt = 0;
        idle(1);
        check_eq("midrst_o_valid", O_valid, 0);
        check_eq("midrst_o_data", O_data, 0);
        check_eq("midrst_o_user", O_user, 0);
        check_eq("midrst_o_ready", O_ready, 1);
        I_rst = 1'b0;
        idle(20);
        check_eq("midrst_no_outputs", out_cnt, 0);

`ifdef DEGAMMA_BYPASS_EN
        // Bypass path: x[11:4], same latency as the normal path.
        lat_en = 1'b1;
        tb_byp = 1'b1;
        send(12'hABC, 3'b110, 8'hAB);
        tb_byp = 1'b0;
        send(12'hABC, 3'b001, ref_fn(12'hABC));
        lat_en = 1'b0;
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/degamma_1_8.md
# degamma_1_8

Inverse gamma (linearization) stage for the ISP: converts a 12-bit gamma-1.8-encoded pixel component back to an 8-bit linear value. It sits wherever linear-domain processing follows gamma-encoded data, such as a blend, statistics or re-encode path. It is built as an 8-stage pipelined binary search over a 255-entry threshold ROM, with valid/ready flow control and a user sideband carried through.

## Interface
- USER_W, default 3: width of the sideband (e.g. {vs, hs, de}) carried alongside each pixel.
- I_clk  in  1  clock; all logic is on the rising edge.
- I_rst  in  1  reset, synchronous, active-high.
- I_data  in  12  gamma-encoded input x, range 0..4095.
- I_user  in  USER_W  sideband accompanying I_data.
- I_valid  in  1  input word valid.
- O_ready  out  1  block can accept an input this cycle.
- O_data  out  8  linear output.
- O_user  out  USER_W  sideband, delayed by exactly the data latency.
- O_valid  out  1  output word valid.
- I_ready  in  1  downstream accepts O_data this cycle.
- I_bypass  in  1  present only with DEGAMMA_BYPASS_EN.

## Operation
- Transfer function: O_data = clamp(round_half_up(255·(x/4095)^1.8), 0, 255).
- Threshold ROM T[k], k=1..255: T[k] = ceil(4095·((k−0.5)/255)^(1/1.8)). T is strictly increasing, T[1] > 0, T[255] ≤ 4095.
- Equivalent integer rule: O_data = number of k with x ≥ T[k].
- Binary search:
  - Stage s, for s = 7 down to 0, resolves output bit s.
  - Candidate c = prefix | (1<<s). If x ≥ T[c], bit s = 1; otherwise 0.
  - Every stage holds its own combinational view of T (case decode); there is no shared ROM port.
- Each stage registers x, the partial result, the user sideband and a valid bit.
- Flow control: a global advance signal, en = ~O_valid | I_ready.
  - O_ready = en.
  - The input is accepted when I_valid & en.
  - All stages shift only when en is 1. When en is 0, every register holds.
- Bubbles (valid = 0) propagate normally, and a stalled output does not lose data.
- A word stays in its stage until en is 1. This is a pure pipeline with no skid buffer, so throughput is 1 word/cycle when I_ready is held at 1.

## Timing
- Latency is 8 cycles from an accepted input edge to O_valid, provided en stays 1.
- O_user is aligned to O_data for every word.
- O_ready is combinational from O_valid and I_ready. There is no combinational path from I_valid or I_data to any output.
- Reset:
  - All stage valids clear, so O_valid = 0.
  - O_data = 0 and O_user = 0.
  - O_ready = 1 in the cycle after reset.
- Reset mid-stream discards all in-flight words. No partial word may appear afterwards.
- Simultaneous I_valid with I_ready = 0 while O_valid = 1: the input is not accepted (O_ready = 0), and the upstream source must hold its word.
- Boundaries:
  - x = 0 gives 0.
  - x = T[k]−1 gives k−1.
  - x = T[k] gives k.
  - x ≥ T[255] gives 255.
  - No overflow is possible because the result is at most 8 bits.

## Configuration
- DEGAMMA_BYPASS_EN defined:
  - The I_bypass port exists and is registered with the input word, travelling down the pipeline.
  - For a word captured with I_bypass = 1, O_data = x[11:4].
  - Latency and handshake are identical to the normal path.
- DEGAMMA_BYPASS_EN undefined:
  - The port and its logic are absent.
  - The transfer function is always applied.

## Test plan
- Reset then stream: after I_rst is released, drive x = 0, 1024, 2048, 4095 back-to-back with I_ready = 1. Expect O_data = 0, 21, 73, 255 on 4 consecutive cycles, the first appearing 8 cycles after the first accept.
- Threshold edges: for every k, drive T[k]−1 and T[k]. Expect outputs k−1 and k. Also run an exhaustive x = 0..4095 sweep against a reference model.
- Backpressure: hold I_ready = 0 for 5 cycles mid-stream while I_valid = 1.
  - O_ready = 0 during the stall.
  - O_data and O_valid stay constant.
  - No word is lost or duplicated, and order is preserved.
- Sideband: send I_user = 3'b101, 3'b010, 3'b111 with bubbles interleaved. O_user must match each word's own value, with valid gaps preserved.
- Reset mid-operation: assert I_rst with 5 words in flight.
  - The next cycle has O_valid = 0, O_data = 0 and O_user = 0.
  - None of the 5 words appears after reset is released.
- Bypass (DEGAMMA_BYPASS_EN): x = 12'hABC with I_bypass = 1 gives O_data = 8'hAB after 8 cycles, with the same latency as the normal path.
